// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a power-of-two FIFO feeding a start/data/parity/stop
// serialiser that sends queued frames back-to-back with no idle gap between them.
module uart_tx_buffered #(
    parameter int CLK_HZ       = 20_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [PAYLOAD_BITS-1:0]          wr_data,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    output logic                             uart_txd,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int CNT_W = $clog2(STOP_BITS * CPB + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(PAYLOAD_BITS);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CPB - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    txd_q, txd_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        count_q, count_d;
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];

    logic push, pop, fifo_nonempty, bit_done, parity_bit;

    assign wr_ready      = (count_q != FULL_CNT);
    assign fifo_count    = count_q;
    assign busy          = (state_q != S_IDLE) || fifo_nonempty;
    assign uart_txd      = txd_q;
    assign push          = wr_valid && wr_ready;
    assign fifo_nonempty = (count_q != '0);
    assign bit_done      = (cnt_q == BIT_END);
    assign parity_bit    = (PARITY == 1) ? ~(^data_q) : ^data_q;

    // txd_d is the line value for the cycle after this edge, so the pin is a plain flop.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        data_d  = data_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    txd_d   = data_q[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = parity_bit;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        txd_d = data_q[idx_d];
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                // The last stop cycle chains straight into the next start bit when data waits.
                if (cnt_q == STOP_END) begin
                    cnt_d = '0;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        data_d  = mem_q[rd_ptr_q];
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is not reset; occupancy comes only from count_q.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLK_HZ, default 20_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, line rate in bits/s.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame; legal range 5..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, transmit buffer entries; power of two, minimum 2.
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 SHALL have port resetn, input, 1 bit, synchronous active-low reset.
REQ-009 SHALL have port wr_data, input, PAYLOAD_BITS bits, byte to enqueue.
REQ-010 SHALL have port wr_valid, input, 1 bit, write request.
REQ-011 SHALL have port wr_ready, output, 1 bit, FIFO can accept (not full).
REQ-012 SHALL have port uart_txd, output, 1 bit, serial line; idle high.
REQ-013 SHALL have port busy, output, 1 bit, frame in flight or FIFO non-empty.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1) bits, current FIFO occupancy.

Function
REQ-015 SHALL compute CPB = CLK_HZ/BIT_RATE (integer division); each line bit is held exactly CPB clk cycles.
REQ-016 SHALL accept a write on a rising edge where wr_valid=1 and wr_ready=1; wr_ready SHALL equal (fifo_count != FIFO_DEPTH) combinationally.
REQ-017 SHALL ignore wr_valid while full: no data lost or overwritten, fifo_count unchanged.
REQ-018 SHALL handle write and pop on the same edge: fifo_count unchanged, both take effect, FIFO order preserved.
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY state is skipped when PARITY=0.
REQ-020 IDLE: uart_txd=1; on an edge with fifo_count>0, SHALL pop the FIFO head into the shift register and enter START.
REQ-021 START: uart_txd=0 for CPB cycles, then DATA.
REQ-022 DATA: SHALL send PAYLOAD_BITS bits, LSB first, CPB cycles each, then PARITY or STOP.
REQ-023 PARITY: SHALL send XOR of the data bits (even) or its inverse (odd) for CPB cycles.
REQ-024 STOP: uart_txd=1 for STOP_BITS*CPB cycles; at the end, if fifo_count>0 SHALL pop and enter START on that same edge (no idle gap), else enter IDLE.
REQ-025 A write into an empty FIFO with the FSM in IDLE SHALL give uart_txd=0 from the edge after the accepting edge (one-cycle latency).
REQ-026 Frame length SHALL be (1+PAYLOAD_BITS+(PARITY!=0)+STOP_BITS)*CPB cycles exactly.
REQ-027 uart_txd SHALL be driven from a register (glitch-free).
REQ-028 busy SHALL be 1 whenever the state is not IDLE or fifo_count>0.
REQ-029 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be determined by fifo_count.

Reset
REQ-030 On an edge with resetn=0: state=IDLE, uart_txd=1, FIFO emptied, fifo_count=0, busy=0, wr_ready=1, baud counter and bit index cleared.
REQ-031 Reset mid-frame SHALL abort the frame immediately (uart_txd=1 after that edge) and discard all queued data; writes on a reset edge SHALL be dropped.

Verification (CLK_HZ=1_000_000, BIT_RATE=100_000, CPB=10, PAYLOAD_BITS=8, FIFO_DEPTH=4 unless noted)
REQ-032 SHALL check: write 0x55, PARITY=0, STOP_BITS=1 -> txd 0,1,0,1,0,1,0,1,0,1 at 10 cycles each, start bit one cycle after the write, busy low 100 cycles after the start bit.
REQ-033 SHALL check: write 0x55 with PARITY=2 -> parity bit 0; with PARITY=1 -> parity bit 1; frame length 110 cycles.
REQ-034 SHALL check: 5 consecutive writes 0x01..0x05 -> first 4 accepted plus one popped immediately; wr_ready low while fifo_count=4; all accepted bytes sent back-to-back in order with no idle cycles between frames.
REQ-035 SHALL check: STOP_BITS=2 -> stop high for 20 cycles before the next start bit.
REQ-036 SHALL check: resetn=0 for one cycle during DATA with 2 bytes queued -> uart_txd=1, fifo_count=0, busy=0 on the next cycle; no further frames sent.
REQ-037 SHALL check: with FIFO full, write on the same edge as a pop (end of STOP) while wr_ready=0 -> write ignored; write one cycle later accepted, count back to 4.
